// File: rtl/integer_to_floating_point.sv
`default_nettype none
// ============================================================================
// integer_to_floating_point : 64-bit int (signed/unsigned) to IEEE-754 double,
// round-to-nearest-even, iterative normalize then single-cycle round.
// Revision: 1.0
// ============================================================================
module integer_to_floating_point (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] int_in,
    input  logic        int_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] fp_out,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [63:0] mag, mag_nx;
    logic [10:0] exp, exp_nx;
    logic        sign, sign_nx;
    logic [63:0] fp_nx;
    logic        inexact_nx;

    logic [51:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [52:0] frac_inc;
    logic [51:0] frac_rnd;
    logic [10:0] exp_rnd;
    logic [63:0] neg_in;

    always_comb begin
        frac     = mag[62:11];
        guard    = mag[10];
        sticky   = |mag[9:0];
        round_up = guard & (sticky | frac[0]);
        frac_inc = {1'b0, frac} + 53'd1;
        neg_in   = ~int_in + 64'd1;
    end

    always_comb begin
        state_nx   = state;
        mag_nx     = mag;
        exp_nx     = exp;
        sign_nx    = sign;
        fp_nx      = fp_out;
        inexact_nx = inexact;
        frac_rnd   = frac;
        exp_rnd    = exp;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nx = ~int_unsigned & int_in[63];
                    mag_nx  = sign_nx ? neg_in : int_in;
                    exp_nx  = 11'd1086;
                    if (int_in == 64'd0) begin
                        // Zero is always +0, even for signed input
                        sign_nx    = 1'b0;
                        fp_nx      = 64'd0;
                        inexact_nx = 1'b0;
                        state_nx   = DONE;
                    end else begin
                        state_nx = NORM;
                    end
                end
            end
            NORM: begin
                if (mag[63:48] == 16'd0) begin
                    mag_nx = mag << 16;
                    exp_nx = exp - 11'd16;
                end else if (!mag[63]) begin
                    mag_nx = mag << 1;
                    exp_nx = exp - 11'd1;
                end else begin
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                if (round_up) begin
                    // Mantissa carry-out bumps the exponent; cannot exceed 1087
                    if (frac_inc[52]) begin
                        frac_rnd = 52'd0;
                        exp_rnd  = exp + 11'd1;
                    end else begin
                        frac_rnd = frac_inc[51:0];
                    end
                end
                fp_nx      = {sign, exp_rnd, frac_rnd};
                inexact_nx = guard | sticky;
                state_nx   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            mag     <= 64'd0;
            exp     <= 11'd0;
            sign    <= 1'b0;
            fp_out  <= 64'd0;
            inexact <= 1'b0;
        end else begin
            state   <= state_nx;
            mag     <= mag_nx;
            exp     <= exp_nx;
            sign    <= sign_nx;
            fp_out  <= fp_nx;
            inexact <= inexact_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_integer_to_floating_point.sv
`default_nettype none
// ============================================================================
// tb_integer_to_floating_point : directed vectors with hand-computed results.
// Revision: 1.0
// ============================================================================
module tb_integer_to_floating_point;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] int_in;
    logic        int_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fp_out;
    logic        inexact;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [63:0] val;
        logic        uns;
        logic [63:0] fp;
        logic        inex;
        logic [31:0] lat;
    } vec_t;

    integer_to_floating_point dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .int_in       (int_in),
        .int_unsigned (int_unsigned),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fp_out       (fp_out),
        .inexact      (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepts one operand and waits for out_valid; lat = -1 on timeout.
    task automatic convert(input logic [63:0] v, input logic u, input logic hold,
                           output logic [63:0] fp, output logic inex, output int lat);
        int waited;
        lat    = -1;
        fp     = 64'd0;
        inex   = 1'b0;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) return;
        int_in       = v;
        int_unsigned = u;
        in_valid     = 1'b1;
        out_ready    = hold;
        @(posedge clk); #1;
        in_valid     = 1'b0;
        int_in       = 64'hA5A5_5A5A_DEAD_BEEF;
        int_unsigned = ~u;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            lat = -1;
            return;
        end
        fp   = fp_out;
        inex = inexact;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (fp_out !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_fp_out: got %h expected 0", fp_out);
        end
        vectors++;
        if (inexact !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_inexact: got %b expected 0", inexact);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_table(input string name, input vec_t tbl[], input logic hold);
        logic [63:0] fp;
        logic        inex;
        int          lat;
        foreach (tbl[i]) begin
            convert(tbl[i].val, tbl[i].uns, hold, fp, inex, lat);
            vectors++;
            if (lat !== int'(tbl[i].lat)) begin
                miscompares++;
                $display("FAIL %s[%0d]_latency in=%h: got %0d expected %0d",
                         name, i, tbl[i].val, lat, tbl[i].lat);
            end
            vectors++;
            if (fp !== tbl[i].fp) begin
                miscompares++;
                $display("FAIL %s[%0d]_fp in=%h: got %h expected %h",
                         name, i, tbl[i].val, fp, tbl[i].fp);
            end
            vectors++;
            if (inex !== tbl[i].inex) begin
                miscompares++;
                $display("FAIL %s[%0d]_inexact in=%h: got %b expected %b",
                         name, i, tbl[i].val, inex, tbl[i].inex);
            end
            if (!hold) release_out();
            else begin
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_conversions();
        vec_t tbl[];
        tbl = new[7];
        tbl[0] = {64'h0000_0000_0000_0001, 1'b0, 64'h3FF0_0000_0000_0000, 1'b0, 32'd20};
        tbl[1] = {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hBFF0_0000_0000_0000, 1'b0, 32'd20};
        tbl[2] = {64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 32'd0};
        tbl[3] = {64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b0, 32'd0};
        tbl[4] = {64'h8000_0000_0000_0000, 1'b0, 64'hC3E0_0000_0000_0000, 1'b0, 32'd2};
        tbl[5] = {64'h8000_0000_0000_0000, 1'b1, 64'h43E0_0000_0000_0000, 1'b0, 32'd2};
        tbl[6] = {64'h0000_0000_0000_03E8, 1'b1, 64'h408F_4000_0000_0000, 1'b0, 32'd11};
        run_table("conv", tbl, 1'b0);
    endtask

    // out_ready held high throughout: it must not disturb NORM/ROUND
    task automatic test_rounding();
        vec_t tbl[];
        tbl = new[3];
        tbl[0] = {64'h0020_0000_0000_0001, 1'b0, 64'h4340_0000_0000_0000, 1'b1, 32'd12};
        tbl[1] = {64'h0020_0000_0000_0003, 1'b0, 64'h4340_0000_0000_0002, 1'b1, 32'd12};
        tbl[2] = {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h43F0_0000_0000_0000, 1'b1, 32'd2};
        run_table("round", tbl, 1'b1);
    endtask

    task automatic test_back_pressure();
        logic [63:0] fp;
        logic        inex;
        int          lat;
        convert(64'd1000, 1'b0, 1'b0, fp, inex, lat);
        vectors++;
        if (lat !== 11) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d expected 11", lat);
        end
        int_in   = 64'd2;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || fp_out !== 64'h408F_4000_0000_0000) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b fp=%h expected 1 0 408f400000000000",
                         c, out_valid, in_ready, fp_out);
            end
        end
        in_valid = 1'b0;
        release_out();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_norm();
        logic [63:0] fp;
        logic        inex;
        int          lat;
        int_in       = 64'd1;
        int_unsigned = 1'b0;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fp_out !== 64'd0 || inexact !== 1'b0) begin
            miscompares++;
            $display("FAIL midnorm_reset: got ready=%b valid=%b fp=%h inexact=%b expected 1 0 0 0",
                     in_ready, out_valid, fp_out, inexact);
        end
        convert(64'd2, 1'b0, 1'b0, fp, inex, lat);
        vectors++;
        if (lat !== 19) begin
            miscompares++;
            $display("FAIL midnorm_next_latency: got %0d expected 19", lat);
        end
        vectors++;
        if (fp !== 64'h4000_0000_0000_0000 || inex !== 1'b0) begin
            miscompares++;
            $display("FAIL midnorm_next_fp: got %h/%b expected 4000000000000000/0", fp, inex);
        end
        release_out();
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        in_valid     = 1'b0;
        int_in       = 64'd0;
        int_unsigned = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_conversions();
        test_rounding();
        test_back_pressure();
        test_reset_mid_norm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
